// File: rtl/branch_resolve.sv
// Branch resolution: architectural {N,V,Z} flag register, condition evaluation
// with same-cycle flag forwarding, fetch redirect and a two-cycle flush sequence.
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | accepting branches and flag updates
// FLUSH1 | first squash cycle after a taken branch
// FLUSH2 | second squash cycle, returns to IDLE
module branch_resolve (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [3:0]  alu_op,
  input  logic [2:0]  alu_flags,
  input  logic        br_valid,
  output logic        br_ready,
  input  logic [2:0]  br_cond,
  input  logic [15:0] br_target,
  output logic [2:0]  flags_q,
  output logic        br_done,
  output logic        br_taken,
  output logic        redirect_valid,
  output logic [15:0] redirect_pc,
  output logic        flush,
  output logic [15:0] taken_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLUSH1 = 2'd1,
    FLUSH2 = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_NOR = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;

  localparam logic [2:0] CC_NEQ   = 3'b000;
  localparam logic [2:0] CC_EQ    = 3'b001;
  localparam logic [2:0] CC_GT    = 3'b010;
  localparam logic [2:0] CC_LT    = 3'b011;
  localparam logic [2:0] CC_GTE   = 3'b100;
  localparam logic [2:0] CC_LTE   = 3'b101;
  localparam logic [2:0] CC_OVFL  = 3'b110;
  localparam logic [2:0] CC_UNCND = 3'b111;

  state_t     state, next_state;
  logic       accept;
  logic       flag_upd;
  logic [2:0] wr_mask;
  logic [2:0] flags_fwd;
  logic       cond_true;
  logic       resolve_taken;

  always_comb begin
    wr_mask = 3'b000;
    case (alu_op)
      OP_ADD, OP_SUB:                          wr_mask = 3'b111;
      OP_AND, OP_NOR, OP_SLL, OP_SRL, OP_SRA:  wr_mask = 3'b001;
      default:                                 wr_mask = 3'b000;
    endcase
  end

  // Bits the current opcode writes come straight from the ALU, the rest from flags_q.
  always_comb begin
    br_ready  = (state == IDLE);
    flush     = (state != IDLE);
    accept    = br_valid && br_ready;
    flag_upd  = alu_valid && (state == IDLE);
    flags_fwd = flag_upd ? ((alu_flags & wr_mask) | (flags_q & ~wr_mask)) : flags_q;
  end

  always_comb begin
    cond_true = 1'b0;
    case (br_cond)
      CC_NEQ:   cond_true = !flags_fwd[0];
      CC_EQ:    cond_true = flags_fwd[0];
      CC_GT:    cond_true = !flags_fwd[0] && !flags_fwd[2];
      CC_LT:    cond_true = flags_fwd[2];
      CC_GTE:   cond_true = flags_fwd[0] || !flags_fwd[2];
      CC_LTE:   cond_true = flags_fwd[2] || flags_fwd[0];
      CC_OVFL:  cond_true = flags_fwd[1];
      CC_UNCND: cond_true = 1'b1;
      default:  cond_true = 1'b0;
    endcase
    resolve_taken = accept && cond_true;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (resolve_taken) next_state = FLUSH1;
      FLUSH1:  next_state = FLUSH2;
      FLUSH2:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q        <= 3'b000;
      br_done        <= 1'b0;
      br_taken       <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 16'h0000;
      taken_cnt      <= 16'h0000;
    end else begin
      br_done        <= accept;
      br_taken       <= resolve_taken;
      redirect_valid <= resolve_taken;
      if (flag_upd)
        flags_q <= flags_fwd;
      if (resolve_taken)
        redirect_pc <= br_target;
      if (resolve_taken && (taken_cnt != 16'hFFFF))
        taken_cnt <= taken_cnt + 16'd1;
    end
  end

endmodule
